id_ex_stage: RTL and testbench

//  Decode->execute pipeline register. Latches the decoded instruction, operands and

---
 rtl/id_ex_stage_pkg.sv | 24 ++
 rtl/id_ex_stage_hazard_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared constants and types for the ID/EX pipeline register
package id_ex_stage_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ALU  = 5'b11011;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } halt_state_e;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use hazard compare between EX load and decode sources
module id_ex_stage_hazard_detect #(
  parameter int RW = 3
) (
  input  logic          ex_valid_i,
  input  logic          ex_mem_rd_i,
  input  logic [RW-1:0] ex_wr_reg_i,
  input  logic          id_valid_i,
  input  logic          id_uses_rs_i,
  input  logic          id_uses_rt_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  output logic          hz_o
);

  logic rs_dep, rt_dep;

  assign rs_dep = id_uses_rs_i & (ex_wr_reg_i == id_rs_i);
  assign rt_dep = id_uses_rt_i & (ex_wr_reg_i == id_rt_i);
  assign hz_o   = ex_valid_i & ex_mem_rd_i & id_valid_i & (rs_dep | rt_dep);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode->execute pipeline register with load-use stall, flush and HALT FSM
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [15:0]   id_instr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc_inc,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          id_use_imm,
  input  logic [RW-1:0] id_wr_reg,
  input  logic          id_reg_wr,
  input  logic          id_mem_rd,
  input  logic          id_mem_wr,
  input  logic          ex_stall,
  input  logic          flush,
  output logic          id_stall,
  output logic          ex_valid,
  output logic [4:0]    ALU_op,
  output logic [1:0]    ALU_funct,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_pc_inc,
  output logic [RW-1:0] ex_wr_reg,
  output logic          ex_reg_wr,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          halt
);

  halt_state_e   state_q;
  logic          valid_q, halt_q;
  logic [4:0]    op_q;
  logic [1:0]    funct_q;
  logic [DW-1:0] a_q, b_q, rt_q, pc_q;
  logic [RW-1:0] wr_q;
  logic          reg_wr_q, mem_rd_q, mem_wr_q;

  logic          hz, load_en, load_ok;
  logic [DW-1:0] b_d;
  logic          unused_instr_bits;

  assign unused_instr_bits = ^id_instr[4:2];

  id_ex_stage_hazard_detect #(.RW(RW)) u_hazard (
    .ex_valid_i  (valid_q),
    .ex_mem_rd_i (mem_rd_q),
    .ex_wr_reg_i (wr_q),
    .id_valid_i  (id_valid),
    .id_uses_rs_i(id_uses_rs),
    .id_uses_rt_i(id_uses_rt),
    .id_rs_i     (id_instr[10:8]),
    .id_rt_i     (id_instr[7:5]),
    .hz_o        (hz)
  );

  assign id_stall = ~flush & (ex_stall | hz | (state_q != RUN));
  assign load_en  = ~flush & ~ex_stall & ~hz;
  assign load_ok  = id_valid & (state_q == RUN);
  assign b_d      = id_use_imm ? id_imm : id_rt_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halt_q   <= 1'b0;
      valid_q  <= 1'b0;
      op_q     <= '0;
      funct_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rt_q     <= '0;
      pc_q     <= '0;
      wr_q     <= '0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      // EX slot: flush and hazard both kill control; stall holds everything
      if (flush || (!ex_stall && hz)) begin
        valid_q  <= 1'b0;
        reg_wr_q <= 1'b0;
        mem_rd_q <= 1'b0;
        mem_wr_q <= 1'b0;
      end else if (load_en) begin
        valid_q  <= load_ok;
        op_q     <= id_instr[15:11];
        funct_q  <= id_instr[1:0];
        a_q      <= id_rs_data;
        b_q      <= b_d;
        rt_q     <= id_rt_data;
        pc_q     <= id_pc_inc;
        wr_q     <= id_wr_reg;
        reg_wr_q <= id_reg_wr & load_ok;
        mem_rd_q <= id_mem_rd & load_ok;
        mem_wr_q <= id_mem_wr & load_ok;
      end

      unique case (state_q)
        RUN: begin
          if (load_en && load_ok && is_halt(id_instr)) state_q <= HALT_PEND;
        end
        HALT_PEND: begin
          // a flushed HALT was fetched down a mispredicted path
          if (flush) begin
            state_q <= RUN;
          end else if (!ex_stall) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end
        end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

  assign ex_valid   = valid_q;
  assign ALU_op     = op_q;
  assign ALU_funct  = funct_q;
  assign ex_a       = a_q;
  assign ex_b       = b_q;
  assign ex_rt_data = rt_q;
  assign ex_pc_inc  = pc_q;
  assign ex_wr_reg  = wr_q;
  assign ex_reg_wr  = reg_wr_q & valid_q;
  assign ex_mem_rd  = mem_rd_q & valid_q;
  assign ex_mem_wr  = mem_wr_q & valid_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW = 16;
  localparam int RW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_uses_rs, id_uses_rt, id_use_imm;
  logic [15:0]   id_instr;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc_inc;
  logic [RW-1:0] id_wr_reg;
  logic          id_reg_wr, id_mem_rd, id_mem_wr, ex_stall, flush;
  logic          id_stall, ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, halt;
  logic [4:0]    ALU_op;
  logic [1:0]    ALU_funct;
  logic [DW-1:0] ex_a, ex_b, ex_rt_data, ex_pc_inc;
  logic [RW-1:0] ex_wr_reg;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_pc_inc(id_pc_inc), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_use_imm(id_use_imm), .id_wr_reg(id_wr_reg), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .ex_stall(ex_stall),
    .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid), .ALU_op(ALU_op),
    .ALU_funct(ALU_funct), .ex_a(ex_a), .ex_b(ex_b), .ex_rt_data(ex_rt_data),
    .ex_pc_inc(ex_pc_inc), .ex_wr_reg(ex_wr_reg), .ex_reg_wr(ex_reg_wr),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .halt(halt)
  );

  int total = 0;
  int bad   = 0;

  // reference view of the EX slot and the halt progress
  bit            m_valid, m_regwr, m_memrd, m_memwr, m_pending, m_halted;
  logic [4:0]    m_op;
  logic [1:0]    m_fn;
  logic [DW-1:0] m_a, m_b, m_rt, m_pc;
  logic [RW-1:0] m_wr;
  bit            check_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hz();
    bit dep;
    dep = (id_uses_rs && m_wr == id_instr[10:8]) || (id_uses_rt && m_wr == id_instr[7:5]);
    return m_valid && m_memrd && id_valid && dep;
  endfunction

  task automatic kill_slot();
    m_valid = 0; m_regwr = 0; m_memrd = 0; m_memwr = 0;
  endtask

  task automatic tick();
    bit hz, exp_stall, was_rst;
    #1;
    hz = model_hz();
    exp_stall = !flush && (ex_stall || hz || m_pending || m_halted);
    if (check_stall) chk("id_stall", 32'(id_stall), 32'(exp_stall));
    @(posedge clk);
    was_rst = rst;
    if (rst) begin
      kill_slot();
      m_pending = 0; m_halted = 0;
      m_op = '0; m_fn = '0; m_a = '0; m_b = '0; m_rt = '0; m_pc = '0; m_wr = '0;
    end else if (flush) begin
      kill_slot();
      m_pending = 0;
    end else if (ex_stall) begin
    end else if (m_pending) begin
      kill_slot();
      m_pending = 0;
      m_halted  = 1;
    end else if (m_halted || hz) begin
      kill_slot();
    end else begin
      m_valid = id_valid;
      m_op = id_instr[15:11]; m_fn = id_instr[1:0];
      m_a  = id_rs_data;      m_b  = id_use_imm ? id_imm : id_rt_data;
      m_rt = id_rt_data;      m_pc = id_pc_inc; m_wr = id_wr_reg;
      m_regwr = id_valid && id_reg_wr;
      m_memrd = id_valid && id_mem_rd;
      m_memwr = id_valid && id_mem_wr;
      if (id_valid && id_instr[15:11] == 5'b00000) m_pending = 1;
    end
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("halt", 32'(halt), 32'(m_halted));
    chk("ex_reg_wr", 32'(ex_reg_wr), 32'(m_regwr));
    chk("ex_mem_rd", 32'(ex_mem_rd), 32'(m_memrd));
    chk("ex_mem_wr", 32'(ex_mem_wr), 32'(m_memwr));
    if (m_valid || was_rst) begin
      chk("ALU_op", 32'(ALU_op), 32'(m_op));
      chk("ALU_funct", 32'(ALU_funct), 32'(m_fn));
      chk("ex_a", 32'(ex_a), 32'(m_a));
      chk("ex_b", 32'(ex_b), 32'(m_b));
      chk("ex_rt_data", 32'(ex_rt_data), 32'(m_rt));
      chk("ex_pc_inc", 32'(ex_pc_inc), 32'(m_pc));
      chk("ex_wr_reg", 32'(ex_wr_reg), 32'(m_wr));
    end
    check_stall = 1;
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                           input logic [2:0] wr, input logic urs, input logic urt,
                           input logic uimm, input logic rw, input logic mrd, input logic mwr);
    id_valid   = 1;
    id_instr   = {op, rs, rt, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
    id_rs_data = 16'($urandom); id_rt_data = 16'($urandom);
    id_imm     = 16'($urandom); id_pc_inc  = 16'($urandom);
    id_uses_rs = urs; id_uses_rt = urt; id_use_imm = uimm;
    id_wr_reg  = wr;  id_reg_wr  = rw;  id_mem_rd  = mrd; id_mem_wr = mwr;
  endtask

  task automatic rand_inputs();
    logic [4:0] op;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: op = OP_ALU;
      4, 5:       op = OP_ADDI;
      6, 7:       op = OP_LD;
      8:          op = OP_ST;
      default:    op = ($urandom_range(0, 19) == 0) ? OP_HALT : OP_NOP;
    endcase
    set_instr(op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              (op == OP_LD) || ($urandom_range(0, 9) == 0), op == OP_ST);
    id_valid = ($urandom_range(0, 99) < 85);
    rst      = ($urandom_range(0, 99) < 3);
    flush    = ($urandom_range(0, 99) < 8);
    ex_stall = ($urandom_range(0, 99) < 15);
  endtask

  initial begin
    rst = 1; flush = 0; ex_stall = 0;
    set_instr(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 0;
    tick();
    rst = 0;

    set_instr(OP_ALU, 2, 3, 1, 1, 1, 0, 1, 0, 0);
    id_instr[1:0] = 2'b00;
    tick();
    chk("add_op", 32'(ALU_op), 32'(5'b11011));
    chk("add_funct", 32'(ALU_funct), 32'(2'b00));
    chk("add_valid", 32'(ex_valid), 32'(1));

    set_instr(OP_LD, 1, 0, 2, 1, 0, 1, 1, 1, 0);
    tick();
    set_instr(OP_ALU, 2, 4, 3, 1, 1, 0, 1, 0, 0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'(0));
    tick();
    chk("lu_add_valid", 32'(ex_valid), 32'(1));
    chk("lu_add_op", 32'(ALU_op), 32'(OP_ALU));

    set_instr(OP_ADDI, 1, 0, 5, 1, 0, 1, 1, 0, 0);
    tick();
    ex_stall = 1;
    set_instr(OP_ST, 3, 3, 0, 1, 1, 1, 0, 0, 1);
    repeat (3) tick();
    chk("stall_hold_op", 32'(ALU_op), 32'(OP_ADDI));
    ex_stall = 0;

    set_instr(OP_LD, 1, 0, 2, 1, 0, 1, 1, 1, 0);
    tick();
    set_instr(OP_ALU, 2, 2, 3, 1, 1, 0, 1, 0, 0);
    flush = 1;
    tick();
    chk("flush_hz_valid", 32'(ex_valid), 32'(0));
    flush = 0;

    set_instr(OP_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("halt_pend", 32'(halt), 32'(0));
    set_instr(OP_ALU, 1, 2, 3, 1, 1, 0, 1, 0, 0);
    tick();
    chk("halt_set", 32'(halt), 32'(1));
    repeat (3) tick();
    chk("halt_ignores", 32'(ex_valid), 32'(0));
    rst = 1;
    tick();
    rst = 0;

    set_instr(OP_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_instr(OP_ALU, 1, 2, 3, 1, 1, 0, 1, 0, 0);
    flush = 1;
    tick();
    flush = 0;
    tick();
    chk("halt_flushed", 32'(halt), 32'(0));
    chk("run_after_flush", 32'(ex_valid), 32'(1));

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
